// File: rtl/spi_arbiter.sv
// Round-robin arbiter that serialises whole SPI transactions from N_REQ clients
// onto one spi_master, with an enforced ss-high gap and a start timeout.
module spi_arbiter #(
  parameter int N_REQ         = 3,
  parameter int SEND_DATA_LEN = 12,
  parameter int RECV_DATA_LEN = 8,
  parameter int GAP_CLKS      = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N_REQ-1:0]                 req,
  input  logic [N_REQ*SEND_DATA_LEN-1:0]   req_data,
  output logic [N_REQ-1:0]                 gnt,
  output logic [N_REQ-1:0]                 done,
  output logic                             err,
  output logic [RECV_DATA_LEN-1:0]         rsp_data,
  output logic                             spi_en,
  output logic [SEND_DATA_LEN-1:0]         spi_send_data,
  input  logic                             spi_busy,
  input  logic [RECV_DATA_LEN-1:0]         spi_recv_data
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, START, RUN, GAP} state_t;

  state_t                     state_reg, state_next;
  logic [N_REQ-1:0]           gnt_reg, gnt_next;
  logic [N_REQ-1:0]           done_reg, done_next;
  logic                       err_reg, err_next;
  logic                       spi_en_reg, spi_en_next;
  logic [RECV_DATA_LEN-1:0]   rsp_reg, rsp_next;
  logic [SEND_DATA_LEN-1:0]   send_reg, send_next;
  logic [PW-1:0]              ptr_reg, ptr_next;
  logic [7:0]                 timer_reg, timer_next;
  logic [3:0]                 gap_reg, gap_next;

  logic [PW-1:0]              winner;
  logic                       winner_found;
  logic                       arb_go;
  logic                       start_expired;

  assign gnt           = gnt_reg;
  assign done          = done_reg;
  assign err           = err_reg;
  assign rsp_data      = rsp_reg;
  assign spi_en        = spi_en_reg;
  assign spi_send_data = send_reg;

  // Search from ptr+1 upward with wrap; lower offsets overwrite later, so the nearest wins.
  always_comb begin
    int idx;
    idx          = 0;
    winner       = ptr_reg;
    winner_found = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[idx]) begin
        winner       = PW'(idx);
        winner_found = 1'b1;
      end
    end
  end

  assign arb_go        = winner_found && !spi_busy;
  assign start_expired = (timer_reg == 8'(START_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      gnt_reg    <= '0;
      done_reg   <= '0;
      err_reg    <= 1'b0;
      spi_en_reg <= 1'b0;
      rsp_reg    <= '0;
      send_reg   <= '0;
      ptr_reg    <= PW'(N_REQ - 1);
      timer_reg  <= '0;
      gap_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      spi_en_reg <= spi_en_next;
      rsp_reg    <= rsp_next;
      send_reg   <= send_next;
      ptr_reg    <= ptr_next;
      timer_reg  <= timer_next;
      gap_reg    <= gap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (arb_go) state_next = START;
      START: begin
        if (spi_busy)           state_next = RUN;
        else if (start_expired) state_next = GAP;
      end
      RUN:   if (!spi_busy) state_next = GAP;
      GAP:   if (gap_reg == 4'(GAP_CLKS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt_next    = gnt_reg;
    done_next   = '0;
    err_next    = 1'b0;
    spi_en_next = spi_en_reg;
    rsp_next    = rsp_reg;
    send_next   = send_reg;
    ptr_next    = ptr_reg;
    timer_next  = timer_reg;
    gap_next    = gap_reg;
    case (state_reg)
      IDLE: begin
        if (arb_go) begin
          gnt_next    = N_REQ'(1) << winner;
          send_next   = req_data[int'(winner)*SEND_DATA_LEN +: SEND_DATA_LEN];
          spi_en_next = 1'b1;
          ptr_next    = winner;
          timer_next  = '0;
        end
      end
      START: begin
        if (spi_busy) begin
          spi_en_next = 1'b0;
        end else if (start_expired) begin
          // Master never started: finish the transaction with an error, keep old rsp_data.
          spi_en_next = 1'b0;
          done_next   = N_REQ'(1) << ptr_reg;
          err_next    = 1'b1;
          gnt_next    = '0;
          gap_next    = '0;
        end else begin
          timer_next  = timer_reg + 8'd1;
        end
      end
      RUN: begin
        if (!spi_busy) begin
          rsp_next  = spi_recv_data;
          done_next = N_REQ'(1) << ptr_reg;
          gnt_next  = '0;
          gap_next  = '0;
        end
      end
      GAP: gap_next = gap_reg + 4'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter with a behavioural spi_master and a transaction scoreboard.
module tb_spi_arbiter;
  localparam int N  = 3;
  localparam int SL = 12;
  localparam int RL = 8;
  localparam int GC = 4;
  localparam int TO = 16;
  localparam int START_DLY = 2;
  localparam int RUN_LEN   = 10;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*SL-1:0] req_data;
  logic [N-1:0]    gnt, done;
  logic            err;
  logic [RL-1:0]   rsp_data;
  logic            spi_en;
  logic [SL-1:0]   spi_send_data;
  logic            spi_busy;
  logic [RL-1:0]   spi_recv_data;

  spi_arbiter #(.N_REQ(N), .SEND_DATA_LEN(SL), .RECV_DATA_LEN(RL),
                .GAP_CLKS(GC), .START_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data),
    .spi_en(spi_en), .spi_send_data(spi_send_data),
    .spi_busy(spi_busy), .spi_recv_data(spi_recv_data));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  gnt;
    logic [SL-1:0] send;
    logic [RL-1:0] rsp;
    logic          err;
  } txn_t;

  txn_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_done = -1;
  bit   tight = 0;
  bit   model_on = 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RL-1:0] slave_rsp(input logic [SL-1:0] s);
    return s[11:4] ^ 8'h99;
  endfunction

  function automatic txn_t mk(input logic [N-1:0] g, input logic [SL-1:0] s,
                              input logic [RL-1:0] r, input logic e);
    txn_t t;
    t.gnt = g; t.send = s; t.rsp = r; t.err = e;
    return t;
  endfunction

  always @(posedge clk) cyc++;

  // Behavioural spi_master: busy rises START_DLY clks after an en rising edge, lasts RUN_LEN.
  int            m_phase = 0;
  int            m_cnt = 0;
  logic          m_en_prev = 1'b0;
  logic [SL-1:0] m_cap = '0;
  initial begin spi_busy = 1'b0; spi_recv_data = '0; end
  always @(negedge clk) begin
    case (m_phase)
      0: if (model_on && spi_en && !m_en_prev) begin
           m_cap = spi_send_data; m_cnt = START_DLY; m_phase = 1;
         end
      1: begin
           m_cnt--;
           if (m_cnt == 0) begin spi_busy = 1'b1; m_cnt = RUN_LEN; m_phase = 2; end
         end
      default: begin
           m_cnt--;
           if (m_cnt == 0) begin
             spi_busy = 1'b0; spi_recv_data = slave_rsp(m_cap); m_phase = 0;
           end
         end
    endcase
    m_en_prev = spi_en;
  end

  // Scoreboard monitor: peek on spi_en rise, pop on done.
  logic mon_en_prev = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    if (rst_n) begin
      if (spi_en && !mon_en_prev) begin
        chk("sb_nonempty_at_en", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("en_gnt", 32'(gnt), 32'(sb[0].gnt));
          chk("en_send", 32'(spi_send_data), 32'(sb[0].send));
        end
        if (tight && last_done >= 0) chk("gap_spacing", cyc - last_done, GC + 1);
      end
      if (done != '0) begin
        chk("sb_nonempty_at_done", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          t = sb.pop_front();
          chk("done_vec", 32'(done), 32'(t.gnt));
          chk("done_err", 32'(err), 32'(t.err));
          chk("done_rsp", 32'(rsp_data), 32'(t.rsp));
        end
        chk("done_gnt_clear", 32'(gnt), 0);
        last_done = cyc;
        $display("txn t=%0t done=%b err=%b rsp=%h", $time, done, err, rsp_data);
      end
    end
    mon_en_prev = spi_en;
  end

  task automatic wait_done(input string tag);
    int n = 0;
    while (done == '0 && n < 300) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, 32'(done != '0), 1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (!spi_busy && n < 100) begin @(negedge clk); n++; end
    chk({tag, "_busy_seen"}, 32'(spi_busy), 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rsp"}, 32'(rsp_data), 0);
    chk({tag, "_spi_en"}, 32'(spi_en), 0);
    chk({tag, "_send"}, 32'(spi_send_data), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req = '0; req_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Round robin, each requester drops on its own done
    req_data[0*SL +: SL] = 12'h111;
    req_data[1*SL +: SL] = 12'h222;
    req_data[2*SL +: SL] = 12'h333;
    tight = 1; last_done = -1;
    sb.push_back(mk(3'b001, 12'h111, 8'h88, 1'b0));
    sb.push_back(mk(3'b010, 12'h222, 8'hBB, 1'b0));
    sb.push_back(mk(3'b100, 12'h333, 8'hAA, 1'b0));
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wait_done("rr");
      req = req & ~done;
      @(negedge clk);
    end
    chk("rr_sb_empty", 32'(sb.size()), 0);

    // Persistent requesters 0 and 2: requester 1 must never win
    last_done = -1;
    sb.push_back(mk(3'b001, 12'h111, 8'h88, 1'b0));
    sb.push_back(mk(3'b100, 12'h333, 8'hAA, 1'b0));
    sb.push_back(mk(3'b001, 12'h111, 8'h88, 1'b0));
    sb.push_back(mk(3'b100, 12'h333, 8'hAA, 1'b0));
    req = 3'b101;
    for (int i = 0; i < 4; i++) begin
      wait_done("fair");
      if (i == 3) req = '0;
      @(negedge clk);
    end
    chk("fair_sb_empty", 32'(sb.size()), 0);
    tight = 0;
    repeat (GC + 4) @(negedge clk);

    // Single request with one-clock latency
    req_data[0*SL +: SL] = 12'hA5C;
    sb.push_back(mk(3'b001, 12'hA5C, 8'h3C, 1'b0));
    req = 3'b001;
    @(negedge clk);
    chk("single_latency_en", 32'(spi_en), 1);
    chk("single_latency_gnt", 32'(gnt), 32'(3'b001));
    wait_done("single");
    req = '0;
    @(negedge clk);
    chk("single_done_pulse", 32'(done), 0);
    chk("single_err_pulse", 32'(err), 0);
    chk("single_rsp_hold", 32'(rsp_data), 32'h3C);
    repeat (GC + 4) @(negedge clk);

    // Request withdrawn mid-transfer still completes
    req_data[1*SL +: SL] = 12'h5E7;
    sb.push_back(mk(3'b010, 12'h5E7, 8'hC7, 1'b0));
    req = 3'b010;
    wait_busy("wd");
    @(negedge clk);
    req = '0;
    wait_done("wd");
    @(negedge clk);
    repeat (GC + 4) @(negedge clk);

    // Start timeout: master never raises busy
    model_on = 0;
    sb.push_back(mk(3'b010, 12'h5E7, 8'hC7, 1'b1));
    req = 3'b010;
    n = 0;
    while (!spi_en && n < 50) begin @(negedge clk); n++; end
    chk("to_en_seen", 32'(spi_en), 1);
    n = 0;
    while (spi_en && n < 300) begin n++; @(negedge clk); end
    chk("to_en_width", n, TO);
    chk("to_done", 32'(done), 32'(3'b010));
    chk("to_err", 32'(err), 1);
    req = '0;
    @(negedge clk);
    chk("to_done_pulse", 32'(done), 0);
    chk("to_err_pulse", 32'(err), 0);
    model_on = 1;
    repeat (GC + 4) @(negedge clk);

    // Reset during RUN: outputs clear at once, no spi_en until busy falls
    req_data[0*SL +: SL] = 12'h3C0;
    sb.push_back(mk(3'b001, 12'h3C0, 8'hA5, 1'b0));
    req = 3'b001;
    wait_busy("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(mk(3'b001, 12'h3C0, 8'hA5, 1'b0));
    chk("rst_busy_still_high", 32'(spi_busy), 1);
    n = 0;
    while (spi_busy && n < 50) begin
      chk("rst_no_en_while_busy", 32'(spi_en), 0);
      @(negedge clk); n++;
    end
    wait_done("rst");
    req = '0;
    @(negedge clk);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
